// File: rtl/axis_pkt_len_meter.sv
// AXI-Stream packet length meter: taps a stream, measures each packet's byte length into a 2-entry record FIFO.
// Optional macro PKT_LEN_DROP_CNT_EN adds a 32-bit drop_count output counting dropped records.

module find_last_bit #(
  parameter int WIDTH = 32,
  parameter int POS_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [POS_W-1:0] pos
);
  // One-indexed position of the highest set bit; later (higher) hits override earlier ones.
  always_comb begin
    pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) pos = POS_W'(i + 1);
    end
  end
endmodule

module axis_pkt_len_meter #(
  parameter int C_S_AXIS_DATA_WIDTH = 256,
  parameter int LEN_WIDTH           = 16
) (
  input  logic                             axis_aclk,
  input  logic                             axis_resetn,
  input  logic                             s_axis_tvalid,
  input  logic                             s_axis_tready,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                             s_axis_tlast,
  output logic [LEN_WIDTH-1:0]             len_data,
  output logic                             len_sat,
  output logic                             len_valid,
  input  logic                             len_ready,
`ifdef PKT_LEN_DROP_CNT_EN
  output logic [31:0]                      drop_count,
`endif
  output logic                             len_overflow
);
  localparam int BYTES = C_S_AXIS_DATA_WIDTH / 8;
  localparam int POS_W = $clog2(BYTES + 1);
  // One spare bit above the wider operand so the raw sum never wraps before the saturation test.
  localparam int SUM_W = ((LEN_WIDTH > POS_W) ? LEN_WIDTH : POS_W) + 1;
  localparam logic [SUM_W-1:0] LEN_MAX = {{(SUM_W - LEN_WIDTH){1'b0}}, {LEN_WIDTH{1'b1}}};

  logic [LEN_WIDTH-1:0] acc_reg, acc_next;
  logic                 sat_reg, sat_next;
  logic [POS_W-1:0]     last_pos;
  logic [SUM_W-1:0]     addend, sum;
  logic                 sum_over;
  logic [LEN_WIDTH-1:0] rec_len;
  logic                 rec_sat;

  logic       beat, push, pop, full, accept, drop;
  logic       wr_ptr_reg, rd_ptr_reg;
  logic [1:0] count_reg, count_next;
  logic       overflow_reg;
  logic [1:0][LEN_WIDTH-1:0] ent_len;
  logic [1:0]                ent_sat;

  find_last_bit #(.WIDTH(BYTES), .POS_W(POS_W)) u_find_last_bit (
    .vec (s_axis_tkeep),
    .pos (last_pos)
  );

  assign beat     = s_axis_tvalid & s_axis_tready;
  assign addend   = s_axis_tlast ? SUM_W'(last_pos) : SUM_W'(BYTES);
  assign sum      = SUM_W'(acc_reg) + addend;
  assign sum_over = (sum > LEN_MAX);
  assign rec_len  = sum_over ? LEN_MAX[LEN_WIDTH-1:0] : sum[LEN_WIDTH-1:0];
  assign rec_sat  = sat_reg | sum_over;

  always_comb begin
    acc_next = acc_reg;
    sat_next = sat_reg;
    if (beat) begin
      if (s_axis_tlast) begin
        acc_next = '0;
        sat_next = 1'b0;
      end else begin
        acc_next = rec_len;
        sat_next = rec_sat;
      end
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      acc_reg <= '0;
      sat_reg <= 1'b0;
    end else begin
      acc_reg <= acc_next;
      sat_reg <= sat_next;
    end
  end

  // A pop in the same cycle frees the head slot, so a full FIFO can still take the new record.
  assign push   = beat & s_axis_tlast;
  assign pop    = len_valid & len_ready;
  assign full   = (count_reg == 2'd2);
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  always_comb begin
    count_next = count_reg;
    case ({accept, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
      overflow_reg <= 1'b0;
    end else begin
      if (accept) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)    rd_ptr_reg <= ~rd_ptr_reg;
      count_reg    <= count_next;
      overflow_reg <= drop;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_entry
      logic [LEN_WIDTH-1:0] len_reg;
      logic                 sat_reg_e;
      always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
          len_reg   <= '0;
          sat_reg_e <= 1'b0;
        end else if (accept && (wr_ptr_reg == 1'(gi))) begin
          len_reg   <= rec_len;
          sat_reg_e <= rec_sat;
        end
      end
      assign ent_len[gi] = len_reg;
      assign ent_sat[gi] = sat_reg_e;
    end
  endgenerate

  assign len_valid    = (count_reg != 2'd0);
  assign len_data     = len_valid ? ent_len[rd_ptr_reg] : '0;
  assign len_sat      = len_valid ? ent_sat[rd_ptr_reg] : 1'b0;
  assign len_overflow = overflow_reg;

`ifdef PKT_LEN_DROP_CNT_EN
  logic [31:0] drop_cnt_reg;
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) drop_cnt_reg <= '0;
    else if (overflow_reg) drop_cnt_reg <= drop_cnt_reg + 32'd1;
  end
  assign drop_count = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_axis_pkt_len_meter.sv
// Directed bench for axis_pkt_len_meter: a 16-bit and an 8-bit length instance share one tapped stream.
`timescale 1ns/1ps

module tb_axis_pkt_len_meter;
  logic        clk;
  logic        rst_n;
  logic        tvalid, tready, tlast, len_ready;
  logic [31:0] tkeep;
  logic [15:0] len_data16;
  logic        len_sat16, len_valid16, ovf16;
  logic [7:0]  len_data8;
  logic        len_sat8, len_valid8, ovf8;
`ifdef PKT_LEN_DROP_CNT_EN
  logic [31:0] drop16, drop8;
`endif

  int total = 0;
  int bad   = 0;

  axis_pkt_len_meter #(.C_S_AXIS_DATA_WIDTH(256), .LEN_WIDTH(16)) dut (
    .axis_aclk(clk), .axis_resetn(rst_n),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
    .len_data(len_data16), .len_sat(len_sat16), .len_valid(len_valid16),
    .len_ready(len_ready),
`ifdef PKT_LEN_DROP_CNT_EN
    .drop_count(drop16),
`endif
    .len_overflow(ovf16)
  );

  axis_pkt_len_meter #(.C_S_AXIS_DATA_WIDTH(256), .LEN_WIDTH(8)) dut8 (
    .axis_aclk(clk), .axis_resetn(rst_n),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
    .len_data(len_data8), .len_sat(len_sat8), .len_valid(len_valid8),
    .len_ready(len_ready),
`ifdef PKT_LEN_DROP_CNT_EN
    .drop_count(drop8),
`endif
    .len_overflow(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          nbeats;
    logic [31:0] keep;
    logic [15:0] exp16;
    logic        sat16;
    logic [7:0]  exp8;
    logic        sat8;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Drive one beat, let it be clocked in, then sample 1ns after the edge.
  task automatic send_beat(input logic [31:0] keep, input logic last);
    tvalid = 1'b1;
    tkeep  = keep;
    tlast  = last;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tkeep  = '0;
  endtask

  task automatic send_pkt(input int nbeats, input logic [31:0] keep);
    for (int b = 0; b < nbeats; b++) begin
      if (b == nbeats - 1) send_beat(keep, 1'b1);
      else send_beat(32'hFFFF_FFFF, 1'b0);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{3, 32'h0000_00FF, 16'd72,  1'b0, 8'd72,  1'b0};
    vecs[1] = '{1, 32'hFFFF_FFFF, 16'd32,  1'b0, 8'd32,  1'b0};
    vecs[2] = '{1, 32'h0000_0000, 16'd0,   1'b0, 8'd0,   1'b0};
    vecs[3] = '{9, 32'hFFFF_FFFF, 16'd288, 1'b0, 8'd255, 1'b1};
    vecs[4] = '{1, 32'h0000_0001, 16'd1,   1'b0, 8'd1,   1'b0};
    vecs[5] = '{2, 32'h8000_0000, 16'd64,  1'b0, 8'd64,  1'b0};
    vecs[6] = '{8, 32'h0001_0000, 16'd241, 1'b0, 8'd241, 1'b0};
    vecs[7] = '{8, 32'h4000_0000, 16'd255, 1'b0, 8'd255, 1'b0};
    vecs[8] = '{8, 32'h8000_0000, 16'd256, 1'b0, 8'd255, 1'b1};
    vecs[9] = '{1, 32'h0000_0105, 16'd9,   1'b0, 8'd9,   1'b0};

    rst_n = 1'b0; tvalid = 1'b0; tready = 1'b1; tlast = 1'b0; tkeep = '0; len_ready = 1'b0;
    idle_cycle();
    idle_cycle();
    check("reset_valid", {31'd0, len_valid16}, 32'd0);
    check("reset_data",  {16'd0, len_data16}, 32'd0);
    check("reset_sat",   {31'd0, len_sat16}, 32'd0);
    check("reset_ovf",   {31'd0, ovf16}, 32'd0);
    rst_n = 1'b1;
    idle_cycle();

    // Table: each packet measured with the consumer always ready.
    len_ready = 1'b1;
    for (int v = 0; v < 10; v++) begin
      send_pkt(vecs[v].nbeats, vecs[v].keep);
      $display("vec %0d: beats=%0d keep=0x%08h len16=%0d sat16=%0b len8=%0d sat8=%0b",
               v, vecs[v].nbeats, vecs[v].keep, len_data16, len_sat16, len_data8, len_sat8);
      check($sformatf("vec%0d_valid", v), {31'd0, len_valid16}, 32'd1);
      check($sformatf("vec%0d_len16", v), {16'd0, len_data16}, {16'd0, vecs[v].exp16});
      check($sformatf("vec%0d_sat16", v), {31'd0, len_sat16}, {31'd0, vecs[v].sat16});
      check($sformatf("vec%0d_len8", v), {24'd0, len_data8}, {24'd0, vecs[v].exp8});
      check($sformatf("vec%0d_sat8", v), {31'd0, len_sat8}, {31'd0, vecs[v].sat8});
      check($sformatf("vec%0d_ovf", v), {31'd0, ovf16}, 32'd0);
      idle_cycle();
      check($sformatf("vec%0d_popped", v), {31'd0, len_valid16}, 32'd0);
    end

    // Beat without tready must not count.
    tready = 1'b0;
    send_beat(32'hFFFF_FFFF, 1'b0);
    tready = 1'b1;
    send_beat(32'h0000_0001, 1'b1);
    $display("seq noready: len16=%0d", len_data16);
    check("noready_len", {16'd0, len_data16}, 32'd1);
    idle_cycle();

    // Back-pressure: two records retained, third dropped with a single overflow pulse.
    len_ready = 1'b0;
    send_beat(32'h1, 1'b1);
    check("bp_first_valid", {31'd0, len_valid16}, 32'd1);
    check("bp_first_len", {16'd0, len_data16}, 32'd1);
    send_beat(32'h3, 1'b1);
    check("bp_hold_len", {16'd0, len_data16}, 32'd1);
    check("bp_second_ovf", {31'd0, ovf16}, 32'd0);
    send_beat(32'h7, 1'b1);
    $display("seq drop: ovf=%0b head=%0d", ovf16, len_data16);
    check("bp_drop_ovf", {31'd0, ovf16}, 32'd1);
    check("bp_drop_head", {16'd0, len_data16}, 32'd1);
    idle_cycle();
    check("bp_ovf_pulse_end", {31'd0, ovf16}, 32'd0);
`ifdef PKT_LEN_DROP_CNT_EN
    check("bp_drop_count", drop16, 32'd1);
`endif
    len_ready = 1'b1;
    idle_cycle();
    check("bp_drain_second", {16'd0, len_data16}, 32'd2);
    idle_cycle();
    check("bp_drain_empty", {31'd0, len_valid16}, 32'd0);

    // Full FIFO with a pop in the same cycle as a new push: no drop.
    len_ready = 1'b0;
    send_beat(32'h1, 1'b1);
    send_beat(32'h3, 1'b1);
    len_ready = 1'b1;
    send_beat(32'hFF, 1'b1);
    $display("seq pushpop: ovf=%0b head=%0d", ovf16, len_data16);
    check("pp_ovf", {31'd0, ovf16}, 32'd0);
    check("pp_head", {16'd0, len_data16}, 32'd2);
    idle_cycle();
    check("pp_new_rec", {16'd0, len_data16}, 32'd8);
    check("pp_new_valid", {31'd0, len_valid16}, 32'd1);
    idle_cycle();
    check("pp_empty", {31'd0, len_valid16}, 32'd0);
`ifdef PKT_LEN_DROP_CNT_EN
    check("pp_drop_count", drop16, 32'd1);
`endif

    // Asynchronous reset mid-packet with a record pending.
    len_ready = 1'b0;
    send_beat(32'h1, 1'b1);
    send_beat(32'hFFFF_FFFF, 1'b0);
    send_beat(32'hFFFF_FFFF, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, len_valid16}, 32'd0);
    check("arst_data", {16'd0, len_data16}, 32'd0);
`ifdef PKT_LEN_DROP_CNT_EN
    check("arst_drop_count", drop16, 32'd0);
`endif
    idle_cycle();
    rst_n = 1'b1;
    idle_cycle();
    len_ready = 1'b1;
    send_beat(32'hF, 1'b1);
    $display("seq reset: len16=%0d valid=%0b", len_data16, len_valid16);
    check("arst_new_valid", {31'd0, len_valid16}, 32'd1);
    check("arst_new_len", {16'd0, len_data16}, 32'd4);
    check("arst_new_sat", {31'd0, len_sat16}, 32'd0);
    idle_cycle();
    check("arst_no_stale", {31'd0, len_valid16}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_pkt_len_meter.md
AXIS_PKT_LEN_METER -- requirements
Module: axis_pkt_len_meter

Interface
REQ-001 Parameter C_S_AXIS_DATA_WIDTH, default 256, SHALL set the monitored stream data width; BYTES = C_S_AXIS_DATA_WIDTH/8.
REQ-002 Parameter LEN_WIDTH, default 16, SHALL set the packet-length field width.
REQ-003 axis_aclk  input  1  SHALL be the single clock; all state is rising-edge.
REQ-004 axis_resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 s_axis_tvalid  input  1  SHALL be the tapped stream valid.
REQ-006 s_axis_tready  input  1  SHALL be the tapped stream ready (monitor only, never driven).
REQ-007 s_axis_tkeep  input  BYTES  SHALL be the tapped byte-enable mask.
REQ-008 s_axis_tlast  input  1  SHALL be the tapped end-of-packet flag.
REQ-009 len_data  output  LEN_WIDTH  SHALL be the head-record byte length.
REQ-010 len_sat  output  1  SHALL flag that the head-record length saturated.
REQ-011 len_valid  output  1  SHALL indicate a record is available.
REQ-012 len_ready  input  1  SHALL be the consumer acceptance of the head record.
REQ-013 len_overflow  output  1  SHALL pulse one cycle when a completed record is dropped.

Function
REQ-014 A beat SHALL count only when s_axis_tvalid and s_axis_tready are both high.
REQ-015 Non-last beat: accumulator SHALL add BYTES regardless of tkeep.
REQ-016 Last beat: record length SHALL be accumulator plus the one-indexed position of the highest set tkeep bit (0 when tkeep is 0), computed with a find_last_bit instance; accumulator SHALL then clear to 0 in the same cycle.
REQ-017 Accumulation SHALL saturate at 2^LEN_WIDTH-1; the record's len_sat SHALL be 1 if saturation occurred anywhere in that packet, and the sticky flag SHALL clear with the accumulator.
REQ-018 Records SHALL enter a 2-entry FIFO; len_valid SHALL rise in the cycle after the last beat (latency 1) when the FIFO was not full.
REQ-019 The head record SHALL pop when len_valid and len_ready are both high; len_data/len_sat SHALL hold stable while len_valid is high and len_ready is low.
REQ-020 Push to a full FIFO without a same-cycle pop SHALL drop the new record and pulse len_overflow for exactly one cycle, one cycle after the last beat.
REQ-021 Push and pop in the same cycle while full SHALL accept the push with no overflow.
REQ-022 Single-beat packets SHALL produce a record equal to the tkeep last-bit count alone.
REQ-023 Back-to-back last beats on consecutive cycles SHALL each produce an independent record.

Reset
REQ-024 On axis_resetn low, accumulator, sticky saturation flag, and FIFO SHALL clear immediately; len_valid, len_data, len_sat, and len_overflow SHALL read 0.
REQ-025 A packet in progress when reset asserts SHALL be discarded; counting SHALL restart at the first accepted beat after release.

Configuration
REQ-026 With macro PKT_LEN_DROP_CNT_EN defined, output drop_count (32 bits) SHALL increment by one on each len_overflow pulse, wrap at 2^32, and reset to 0.
REQ-027 Without PKT_LEN_DROP_CNT_EN, the drop_count port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification (C_S_AXIS_DATA_WIDTH=256, LEN_WIDTH=16 unless stated)
REQ-028 Three-beat packet, last tkeep=0x000000FF, len_ready=1 -> len_data=72, len_sat=0, len_valid high one cycle after the last beat.
REQ-029 Single beat, tkeep=0xFFFFFFFF, tlast=1 -> len_data=32; single beat with tkeep=0 -> len_data=0.
REQ-030 len_ready=0, three single-beat packets (tkeep 0x1, 0x3, 0x7) -> records 1 then 2 retained, third dropped, one len_overflow pulse, drop_count=1 with PKT_LEN_DROP_CNT_EN.
REQ-031 LEN_WIDTH=8, nine full beats with last tkeep=0xFFFFFFFF (288 bytes) -> len_data=255, len_sat=1; the next 1-beat packet with tkeep=0x1 -> len_data=1, len_sat=0.
REQ-032 Reset asserted after two beats of a packet, released, then one beat with tkeep=0xF, tlast=1 -> single record len_data=4, no stale record.
REQ-033 FIFO full, len_ready=1 in the same cycle a new last beat lands (tkeep=0xFF) -> no overflow, FIFO stays full, new record len_data=8 appears after the two older records drain.
